// File: rtl/riscv_sim_monitor.sv
// Run monitor for RV32I simulation/bring-up: watches fetch PC and data stores, latches a sticky verdict.
// Optional PC trace buffer is compiled in when RISCV_MON_TRACE_EN is defined.
module riscv_sim_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0FFC,
  parameter int unsigned     MAX_CYCLE   = 200,
  parameter int unsigned     HANG_CYCLE  = 8,
  parameter int unsigned     CNT_BIT     = 16,
  parameter int unsigned     TRACE_DEPTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_mon_en,
  input  logic               i_mon_clr,
  input  logic [XLEN-1:0]    i_mon_pc,
  input  logic [XLEN-1:0]    i_mon_dmem_addr,
  input  logic               i_mon_dmem_wr_en,
  input  logic [3:0]         i_mon_dmem_byte_sel,
  input  logic [XLEN-1:0]    i_mon_dmem_wr_data,
  output logic [2:0]         o_mon_state,
  output logic               o_mon_done,
  output logic [XLEN-1:0]    o_mon_code,
  output logic [CNT_BIT-1:0] o_mon_cycle_cnt
`ifdef RISCV_MON_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_mon_trace_idx,
  output logic [XLEN-1:0]                o_mon_trace_pc
`endif
);

  localparam int unsigned         HANG_W     = $clog2(HANG_CYCLE) + 1;
  localparam logic [CNT_BIT-1:0]  TIMEOUT_AT = CNT_BIT'(MAX_CYCLE - 1);
  // Hang fires when the counter would step onto HANG_CYCLE-1, i.e. on its
  // current value HANG_CYCLE-2 while the PC is still unchanged.
  localparam logic [HANG_W-1:0]   HANG_AT    = HANG_W'(HANG_CYCLE - 2);
  localparam logic [CNT_BIT-1:0]  CNT_MAX    = '1;

  if (HANG_CYCLE < 2) begin : g_hang_chk
    $error("riscv_sim_monitor: HANG_CYCLE must be at least 2");
  end
  if ((MAX_CYCLE < 1) || (longint'(MAX_CYCLE) > ((64'sd1 <<< CNT_BIT) - 1))) begin : g_max_chk
    $error("riscv_sim_monitor: MAX_CYCLE must be in 1 .. 2**CNT_BIT-1");
  end
  if ((TRACE_DEPTH < 2) || ((TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("riscv_sim_monitor: TRACE_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_e;

  state_e            state;
  logic [XLEN-1:0]   pc_q;
  logic [HANG_W-1:0] hang_cnt;

  logic tohost_hit;
  logic tohost_pass;
  logic pc_same;
  logic hang_hit;
  logic timeout_hit;

  // The store port has no handshake: any cycle with i_mon_dmem_wr_en high is a
  // completed store, and the monitor never back-pressures the core.
  assign tohost_hit  = i_mon_dmem_wr_en
                    && (i_mon_dmem_addr == TOHOST_ADDR)
                    && (i_mon_dmem_byte_sel == 4'b1111);
  assign tohost_pass = (i_mon_dmem_wr_data == XLEN'(1));
  assign pc_same     = (i_mon_pc == pc_q);
  assign hang_hit    = pc_same && (hang_cnt == HANG_AT);
  assign timeout_hit = (o_mon_cycle_cnt == TIMEOUT_AT);

  assign o_mon_state = state;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state           <= S_IDLE;
      o_mon_done      <= 1'b0;
      o_mon_code      <= '0;
      o_mon_cycle_cnt <= '0;
      hang_cnt        <= '0;
      pc_q            <= '0;
    end else if (i_mon_clr) begin
      state           <= S_IDLE;
      o_mon_done      <= 1'b0;
      o_mon_code      <= '0;
      o_mon_cycle_cnt <= '0;
      hang_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_mon_en) begin
            state           <= S_RUN;
            o_mon_code      <= '0;
            o_mon_cycle_cnt <= '0;
            hang_cnt        <= '0;
          end
        end
        S_RUN: begin
          // The verdict cycle is itself counted, so the count always advances here.
          if (o_mon_cycle_cnt != CNT_MAX) begin
            o_mon_cycle_cnt <= o_mon_cycle_cnt + CNT_BIT'(1);
          end
          hang_cnt <= pc_same ? (hang_cnt + HANG_W'(1)) : '0;
          pc_q     <= i_mon_pc;
          if (tohost_hit) begin
            state      <= tohost_pass ? S_PASS : S_FAIL;
            o_mon_code <= i_mon_dmem_wr_data;
            o_mon_done <= 1'b1;
          end else if (hang_hit) begin
            state      <= S_HANG;
            o_mon_done <= 1'b1;
          end else if (timeout_hit) begin
            state      <= S_TIMEOUT;
            o_mon_done <= 1'b1;
          end
        end
        default: begin
          // Terminal verdicts hold until i_mon_clr or reset.
        end
      endcase
    end
  end

`ifdef RISCV_MON_TRACE_EN
  localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);

  logic [XLEN-1:0]  trace_mem [TRACE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Trace survives i_mon_clr so a post-mortem read is still possible after re-arming.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
        trace_mem[i] <= '0;
      end
    end else if ((state == S_RUN) && !i_mon_clr) begin
      trace_mem[wr_ptr] <= i_mon_pc;
      wr_ptr            <= wr_ptr + PTR_W'(1);
    end
  end

  assign rd_ptr         = wr_ptr - PTR_W'(1) - i_mon_trace_idx;
  assign o_mon_trace_pc = trace_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_riscv_sim_monitor.sv
// Directed bench for riscv_sim_monitor: driver tasks issue cycles, verdicts are scored
// against an expected queue by a separate monitor process.
module tb_riscv_sim_monitor;

  localparam int XLEN    = 32;
  localparam int CNT_BIT = 16;
  localparam int EXP_W   = 3 + XLEN + CNT_BIT;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic               clk = 1'b0;
  logic               rstn;
  logic               en;
  logic               clr;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    addr;
  logic               wr_en;
  logic [3:0]         bsel;
  logic [XLEN-1:0]    wdata;
  logic [2:0]         state;
  logic               done;
  logic [XLEN-1:0]    code;
  logic [CNT_BIT-1:0] cnt;
`ifdef RISCV_MON_TRACE_EN
  logic [2:0]         trace_idx;
  logic [XLEN-1:0]    trace_pc;
`endif

  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic prev_done = 1'b0;

  riscv_sim_monitor #(
    .XLEN(32), .TOHOST_ADDR(32'h0000_0FFC), .MAX_CYCLE(200),
    .HANG_CYCLE(8), .CNT_BIT(16), .TRACE_DEPTH(8)
  ) dut (
    .i_clk               (clk),
    .i_rstn              (rstn),
    .i_mon_en            (en),
    .i_mon_clr           (clr),
    .i_mon_pc            (pc),
    .i_mon_dmem_addr     (addr),
    .i_mon_dmem_wr_en    (wr_en),
    .i_mon_dmem_byte_sel (bsel),
    .i_mon_dmem_wr_data  (wdata),
    .o_mon_state         (state),
    .o_mon_done          (done),
    .o_mon_code          (code),
    .o_mon_cycle_cnt     (cnt)
`ifdef RISCV_MON_TRACE_EN
    ,
    .i_mon_trace_idx     (trace_idx),
    .o_mon_trace_pc      (trace_pc)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, required end of sequence");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: inputs change at a negedge, DUT samples next posedge, results read at following negedge.
  task automatic drive(input logic [31:0] p, input logic we, input logic [31:0] a,
                       input logic [3:0] bs, input logic [31:0] d);
    pc = p; wr_en = we; addr = a; bsel = bs; wdata = d;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] p);
    drive(p, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] p, input logic [31:0] d, input logic [3:0] bs);
    drive(p, 1'b1, TOHOST, bs, d);
  endtask

  task automatic expect_verdict(input logic [2:0] st, input logic [31:0] c, input logic [15:0] n);
    exp_q.push_back({st, c, n});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_code"},  code,       32'd0);
    check({tag, "_cnt"},   32'(cnt),   32'd0);
  endtask

  task automatic start_run(input string tag);
    clr = 1'b1; en = 1'b1;
    fetch(32'h0);
    clr = 1'b0;
    fetch(32'h0);
    en = 1'b0;
    check({tag, "_run_state"}, 32'(state), 32'd1);
    check({tag, "_run_cnt"},   32'(cnt),   32'd0);
  endtask

  // Scoreboard monitor: on each new verdict, pop and compare the expected entry.
  initial begin : monitor
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_verdict: got state=%0d code=0x%0h cnt=%0d, expected none",
                   state, code, cnt);
        end else begin
          e = exp_q.pop_front();
          check("verdict_state", 32'(state), 32'(e[EXP_W-1 -: 3]));
          check("verdict_code",  code,       e[CNT_BIT +: XLEN]);
          check("verdict_cnt",   32'(cnt),   32'(e[CNT_BIT-1:0]));
        end
      end
      prev_done = done;
    end
  end

  initial begin : stimulus
    rstn = 1'b0; en = 1'b1; clr = 1'b0;
    pc = '0; addr = '0; wr_en = 1'b0; bsel = '0; wdata = '0;
`ifdef RISCV_MON_TRACE_EN
    trace_idx = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");

    // PASS at RUN cycle 10; en stays high throughout
    rstn = 1'b1;
    fetch(32'h0);
    check("enter_state", 32'(state), 32'd1);
    check("enter_cnt",   32'(cnt),   32'd0);
    for (int k = 0; k < 9; k++) fetch(32'(k * 4));
    check("pre_pass_cnt", 32'(cnt), 32'd9);
    expect_verdict(3'd2, 32'd1, 16'd10);
    store(32'h24, 32'd1, 4'b1111);
    check("pass_done", 32'(done), 32'd1);
    store(32'h28, 32'd7, 4'b1111);
    fetch(32'h2C);
    check("pass_sticky_state", 32'(state), 32'd2);
    check("pass_sticky_code",  code,       32'd1);
    check("pass_sticky_cnt",   32'(cnt),   32'd10);

    // FAIL with code 7, later store of 1 ignored
    start_run("fail");
    fetch(32'h100);
    fetch(32'h104);
    expect_verdict(3'd3, 32'd7, 16'd3);
    store(32'h108, 32'd7, 4'b1111);
    store(32'h10C, 32'd1, 4'b1111);
    fetch(32'h110);
    check("fail_sticky_state", 32'(state), 32'd3);
    check("fail_sticky_code",  code,       32'd7);

    // Non-hits, then TIMEOUT at 200
    start_run("tmo");
    store(32'h200, 32'd1, 4'b0001);
    check("partial_store_state", 32'(state), 32'd1);
    drive(32'h204, 1'b1, 32'h0000_0FF8, 4'b1111, 32'd1);
    check("other_addr_state", 32'(state), 32'd1);
    drive(32'h208, 1'b0, TOHOST, 4'b1111, 32'd1);
    check("no_wr_en_state", 32'(state), 32'd1);
    for (int k = 3; k < 199; k++) fetch(32'h200 + 32'(k * 4));
    check("pre_tmo_state", 32'(state), 32'd1);
    check("pre_tmo_cnt",   32'(cnt),   32'd199);
    expect_verdict(3'd4, 32'd0, 16'd200);
    fetch(32'h200 + 32'(199 * 4));
    fetch(32'h600);
    fetch(32'h604);
    check("tmo_frozen_cnt", 32'(cnt), 32'd200);

    // HANG: PC 0,4,8 then holds 8
    start_run("hang");
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    for (int k = 0; k < 6; k++) fetch(32'h8);
    check("pre_hang_state", 32'(state), 32'd1);
    expect_verdict(3'd5, 32'd0, 16'd10);
    fetch(32'h8);
    check("hang_state", 32'(state), 32'd5);

    // Tohost hit on the hang-threshold cycle wins
    start_run("hangpass");
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    for (int k = 0; k < 6; k++) fetch(32'h8);
    expect_verdict(3'd2, 32'd1, 16'd10);
    store(32'h8, 32'd1, 4'b1111);
    check("hangpass_state", 32'(state), 32'd2);

    // Async reset mid-run, then clr from PASS and a fresh run
    start_run("rst");
    for (int k = 0; k < 5; k++) fetch(32'h300 + 32'(k * 4));
    #2 rstn = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    fetch(32'h400);
    check("idle_hold_state", 32'(state), 32'd0);
    en = 1'b1;
    fetch(32'h400);
    en = 1'b0;
    check("rerun_cnt", 32'(cnt), 32'd0);
    fetch(32'h400); fetch(32'h404);
    expect_verdict(3'd2, 32'd1, 16'd3);
    store(32'h408, 32'd1, 4'b1111);
    clr = 1'b1;
    fetch(32'h40C);
    clr = 1'b0;
    check_zero("clr_from_pass");
    en = 1'b1;
    fetch(32'h500);
    en = 1'b0;
    check("fresh_state", 32'(state), 32'd1);
    check("fresh_cnt0",  32'(cnt),   32'd0);
    fetch(32'h500); fetch(32'h504);
    check("fresh_cnt2", 32'(cnt), 32'd2);

`ifdef RISCV_MON_TRACE_EN
    // Trace: ten fetches 0x0..0x24, verdict on the last
    start_run("trace");
    for (int k = 0; k < 9; k++) fetch(32'(k * 4));
    expect_verdict(3'd2, 32'd1, 16'd10);
    store(32'h24, 32'd1, 4'b1111);
    trace_idx = 3'd0; #1 check("trace_idx0", trace_pc, 32'h24);
    trace_idx = 3'd7; #1 check("trace_idx7", trace_pc, 32'h8);
    trace_idx = 3'd3; #1 check("trace_idx3", trace_pc, 32'h18);
    fetch(32'h700);
    fetch(32'h704);
    trace_idx = 3'd0; #1 check("trace_frozen", trace_pc, 32'h24);
`endif

    fetch(32'h0);
    fetch(32'h0);
    check("verdicts_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_sim_monitor.md
# riscv_sim_monitor

Parametrised run monitor for RV32I core simulation and FPGA bring-up. Sits beside `riscv_top` and snoops the instruction-fetch PC and the data-memory write port. It detects the tohost pass/fail signature, a PC hang and a cycle-budget timeout, then latches a sticky verdict with cycle and code counters. The bench no longer hard-codes a fixed cycle count and inspects waveforms; it polls this block instead.

## Interface
- `XLEN`, 32: data/address width.
- `TOHOST_ADDR`, 32'h0000_0FFC: word address whose full-word store reports the verdict.
- `MAX_CYCLE`, 200: cycle budget in RUN; 1 to 2**`CNT_BIT`-1.
- `HANG_CYCLE`, 8: consecutive cycles with an unchanged PC that declare a hang; ≥2.
- `CNT_BIT`, 16: cycle-counter width.
- `TRACE_DEPTH`, 8: PC history entries; power of two, ≥2.

Ports:
- `i_clk` in 1: clock.
- `i_rstn` in 1: asynchronous, active-low reset.
- `i_mon_en` in 1: start monitoring; sampled in IDLE.
- `i_mon_clr` in 1: synchronous return to IDLE from any state.
- `i_mon_pc` in XLEN: current fetch PC.
- `i_mon_dmem_addr` in XLEN: store address.
- `i_mon_dmem_wr_en` in 1: store strobe.
- `i_mon_dmem_byte_sel` in 4: store byte enables.
- `i_mon_dmem_wr_data` in XLEN: store data.
- `o_mon_state` out 3: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5.
- `o_mon_done` out 1: state ≥2.
- `o_mon_code` out XLEN: latched tohost data; 0 otherwise.
- `o_mon_cycle_cnt` out CNT_BIT: cycles spent in RUN.
- `i_mon_trace_idx` in log2(TRACE_DEPTH): trace read index, 0 = newest (present only with the trace feature).
- `o_mon_trace_pc` out XLEN: trace read data (present only with the trace feature).

## Operation
- Reset: state IDLE, `o_mon_done`=0, `o_mon_code`=0, `o_mon_cycle_cnt`=0, hang counter 0, stored `pc_q`=0, trace pointer 0, trace entries 0.
- IDLE→RUN when `i_mon_en`=1. Counters clear on entry.
- In RUN, every cycle:
  - Cycle count increments.
  - Hang counter increments when `i_mon_pc`==`pc_q`; otherwise it resets to 0.
  - `pc_q` is updated from `i_mon_pc`.
- A tohost hit is `wr_en`=1, `addr`==`TOHOST_ADDR` and `byte_sel`==4'b1111. Partial stores to `TOHOST_ADDR` are ignored.
- On a hit in RUN: data==1 → PASS; any other data → FAIL. In both cases the data is latched into `o_mon_code`.
- TIMEOUT: the cycle count reaches `MAX_CYCLE`-1 in RUN with no hit that cycle.
- HANG: the hang counter reaches `HANG_CYCLE`-1 with an unchanged PC and no hit that cycle. A `jal x0,0` tail hangs unless tohost was written first.
- Priority in one cycle: `i_mon_clr` > tohost hit > HANG > TIMEOUT.
- PASS, FAIL, TIMEOUT and HANG are sticky. Counters freeze, and further stores are ignored.
- `i_mon_clr` from any state → IDLE, clearing the code and counters. Trace contents are kept.
- The cycle counter saturates at all-ones and never wraps. This is guaranteed because `MAX_CYCLE` ≤ 2**`CNT_BIT`-1.

## Timing
- All outputs are registered.
- Verdict visible the cycle after the hit, timeout or hang cycle.
- `o_mon_cycle_cnt` = N after N RUN cycles. The cycle that enters a terminal state is counted.
- Reset asserted mid-run: immediate IDLE and reset values, with no clock needed.
- `i_mon_en` held high in a terminal state has no effect. Only `i_mon_clr` re-arms the block.

## Configuration
- `RISCV_MON_TRACE_EN` defined:
  - Circular buffer of `TRACE_DEPTH` PCs, written every RUN cycle; the pointer wraps modulo `TRACE_DEPTH`.
  - Frozen in terminal states.
  - `o_mon_trace_pc` is a combinational read of the entry at (wr_ptr-1-`i_mon_trace_idx`) mod `TRACE_DEPTH`.
- `RISCV_MON_TRACE_EN` undefined: the trace ports and storage are absent. All other behaviour is identical.

## Test plan
- Reset with `i_mon_en`=1; at cycle 10 of RUN, store 1 to 0xFFC with `byte_sel` 4'b1111 → next cycle state=2, `o_mon_done`=1, `o_mon_code`=1, `o_mon_cycle_cnt`=10.
- Store 0x0000_0007 to 0xFFC → FAIL, `o_mon_code`=7. A later store of 1 leaves the state at FAIL.
- Store 1 to 0xFFC with `byte_sel` 4'b0001 → ignored, still RUN. Incrementing PC with no hit and `MAX_CYCLE`=200 → TIMEOUT with `o_mon_cycle_cnt`=200.
- PC steps 0,4,8, then holds 0x8 → HANG 7 cycles after the hold begins (`HANG_CYCLE`=8). A tohost hit on the hang-threshold cycle → PASS instead.
- `i_rstn` pulsed low mid-RUN, then `i_mon_clr` from PASS → all outputs return to reset values, and `i_mon_en` starts a fresh run from count 0.
- With `RISCV_MON_TRACE_EN` and PCs 0x0..0x24 (10 fetches, depth 8): idx 0 reads 0x24, idx 7 reads 0x8. Trace stays frozen after a verdict.
